// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    FAULT    = 2'd2
  } hz_state_e;

  localparam int unsigned MDU_MAX_DEFAULT = 34;

  typedef logic [7:0] wait_cnt_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the ID instruction and a load in EX.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes, MDU handshake + watchdog.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_MAX_CYCLES = MDU_MAX_DEFAULT,
  parameter int unsigned STAT_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_ex_memRead,
  input  logic [4:0]        id_ex_rd,
  input  logic              ex_is_mdu,
  input  logic              ex_branch_taken,
  input  logic              mdu_done,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_hold,
  output logic              ex_mem_bubble,
  output logic              mdu_start,
  output logic              mdu_timeout,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_count
);

  localparam wait_cnt_t WaitMax = wait_cnt_t'(MDU_MAX_CYCLES);

  hz_state_e state_q, state_d;
  wait_cnt_t wait_cnt_q, wait_cnt_d;
  logic      load_use;
  logic      mdu_start_raw;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (id_ex_memRead),
    .ex_rd       (id_ex_rd),
    .load_use    (load_use)
  );

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_hold       = 1'b0;
    ex_mem_bubble = 1'b0;
    mdu_start_raw = 1'b0;
    mdu_timeout   = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (ex_is_mdu) begin
          mdu_start_raw = 1'b1;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          ex_hold       = 1'b1;
          ex_mem_bubble = 1'b1;
          state_d       = MDU_WAIT;
          wait_cnt_d    = 8'd1;
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MDU_WAIT: begin
        // Release in the done cycle so EX/MEM captures the result without a bubble.
        if (mdu_done) begin
          state_d = RUN;
        end else begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          ex_hold       = 1'b1;
          ex_mem_bubble = 1'b1;
          if (wait_cnt_q == WaitMax) begin
            state_d = FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      FAULT: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        ex_hold       = 1'b1;
        ex_mem_bubble = 1'b1;
        mdu_timeout   = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // The MDU shares rst_n, so never launch it while reset is held.
  assign mdu_start = mdu_start_raw & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (state_q != FAULT) && !(&stall_q)) begin
        stall_q <= stall_q + STAT_W'(1);
      end
      if ((state_q == RUN) && ex_branch_taken && !ex_is_mdu && !(&flush_q)) begin
        flush_q <= flush_q + STAT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (default watchdog and a 4-cycle watchdog).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_uses_rs1, id_uses_rs2, id_ex_memRead;
  logic       ex_is_mdu, ex_branch_taken, mdu_done;

  logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush;
  logic        a_ex_hold, a_ex_mem_bubble, a_mdu_start, a_mdu_timeout;
  logic [31:0] a_stall, a_flush;
  logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush;
  logic        b_ex_hold, b_ex_mem_bubble, b_mdu_start, b_mdu_timeout;
  logic [31:0] b_stall, b_flush;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: per instance, waiting flag, wait count, fault flag, counters.
  bit          m_wait[2];
  int          m_cnt[2];
  bit          m_fault[2];
  logic [31:0] m_stall[2];
  logic [31:0] m_flush[2];
  int          m_max[2];

  always #5 clk = ~clk;

  hazard_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_ex_memRead(id_ex_memRead),
    .id_ex_rd(id_ex_rd), .ex_is_mdu(ex_is_mdu), .ex_branch_taken(ex_branch_taken),
    .mdu_done(mdu_done), .pc_write(a_pc_write), .if_id_write(a_if_id_write),
    .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush), .ex_hold(a_ex_hold),
    .ex_mem_bubble(a_ex_mem_bubble), .mdu_start(a_mdu_start), .mdu_timeout(a_mdu_timeout),
    .stall_cycles(a_stall), .flush_count(a_flush)
  );

  hazard_ctrl #(.MDU_MAX_CYCLES(4), .STAT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_ex_memRead(id_ex_memRead),
    .id_ex_rd(id_ex_rd), .ex_is_mdu(ex_is_mdu), .ex_branch_taken(ex_branch_taken),
    .mdu_done(mdu_done), .pc_write(b_pc_write), .if_id_write(b_if_id_write),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush), .ex_hold(b_ex_hold),
    .ex_mem_bubble(b_ex_mem_bubble), .mdu_start(b_mdu_start), .mdu_timeout(b_mdu_timeout),
    .stall_cycles(b_stall), .flush_count(b_flush)
  );

  logic [71:0] obs_a, obs_b;
  assign obs_a = {a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_ex_hold,
                  a_ex_mem_bubble, a_mdu_start, a_mdu_timeout, a_stall, a_flush};
  assign obs_b = {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_hold,
                  b_ex_mem_bubble, b_mdu_start, b_mdu_timeout, b_stall, b_flush};

  // Bit order: pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, bubble, start, timeout.
  function automatic logic [71:0] exp_vec(int d);
    logic        lu;
    logic [7:0]  o;
    logic [31:0] s, f;
    lu = id_ex_memRead && (id_ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
    if (m_fault[d])           o = 8'b0000_1101;
    else if (m_wait[d])       o = mdu_done ? 8'b1100_0000 : 8'b0000_1100;
    else if (ex_is_mdu)       o = {6'b0000_11, rst_n, 1'b0};
    else if (ex_branch_taken) o = 8'b1111_0000;
    else if (lu)              o = 8'b0001_0000;
    else                      o = 8'b1100_0000;
`ifdef HAZARD_STATS_EN
    s = m_stall[d];
    f = m_flush[d];
`else
    s = 32'd0;
    f = 32'd0;
`endif
    return {o, s, f};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_wait[d]  = 1'b0;
      m_cnt[d]   = 0;
      m_fault[d] = 1'b0;
      m_stall[d] = 32'd0;
      m_flush[d] = 32'd0;
    end
  endtask

  // Clock edge: advance the model with the inputs that were present at the edge.
  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        logic [71:0] e;
        e = exp_vec(d);
        if (!m_fault[d] && !e[71] && m_stall[d] != 32'hFFFF_FFFF) m_stall[d]++;
        if (!m_fault[d] && !m_wait[d] && ex_branch_taken && !ex_is_mdu &&
            m_flush[d] != 32'hFFFF_FFFF) m_flush[d]++;
        if (m_fault[d]) begin
        end else if (m_wait[d]) begin
          if (mdu_done) m_wait[d] = 1'b0;
          else if (m_cnt[d] == m_max[d]) begin
            m_fault[d] = 1'b1;
            m_wait[d]  = 1'b0;
          end else m_cnt[d]++;
        end else if (ex_is_mdu) begin
          m_wait[d] = 1'b1;
          m_cnt[d]  = 1;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_idle();
    id_rs1 = 0; id_rs2 = 0; id_ex_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_ex_memRead = 0;
    ex_is_mdu = 0; ex_branch_taken = 0; mdu_done = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    set_idle();
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    ex_is_mdu = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ((d == 0 ? obs_a : obs_b) !== exp_vec(d)) begin
        errors++;
        $display("FAIL reset_mdu_gated dut%0d got %h exp %h", d, (d == 0 ? obs_a : obs_b),
                 exp_vec(d));
      end
    end
    ex_is_mdu = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ((d == 0 ? obs_a : obs_b) !== exp_vec(d)) begin
        errors++;
        $display("FAIL reset_idle dut%0d got %h exp %h", d, (d == 0 ? obs_a : obs_b),
                 exp_vec(d));
      end
    end
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    // {memRead, rd, rs1, uses1, rs2, uses2}: hazard via rs2, then clear cases.
    logic [17:0] pat[5];
    pat[0] = {1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1};
    pat[1] = {1'b0, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1};
    pat[2] = {1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1};
    pat[3] = {1'b1, 5'd9, 5'd9, 1'b0, 5'd2, 1'b1};
    pat[4] = {1'b1, 5'd9, 5'd9, 1'b1, 5'd2, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      {id_ex_memRead, id_ex_rd, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2} = pat[i];
      #2;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ((d == 0 ? obs_a : obs_b) !== exp_vec(d)) begin
          errors++;
          $display("FAIL load_use[%0d] dut%0d got %h exp %h", i, d, (d == 0 ? obs_a : obs_b),
                   exp_vec(d));
        end
      end
      advance();
    end
    set_idle();
  endtask

  task automatic test_branch();
    set_idle();
    id_ex_memRead = 1'b1; id_ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ((d == 0 ? obs_a : obs_b) !== exp_vec(d)) begin
          errors++;
          $display("FAIL branch[%0d] dut%0d got %h exp %h", i, d, (d == 0 ? obs_a : obs_b),
                   exp_vec(d));
        end
      end
      advance();
      set_idle();
    end
  endtask

  task automatic test_div_long();
    int          held;
    logic [31:0] stall0;
    held = 0;
    do_reset();
    stall0 = a_stall;
    ex_is_mdu = 1'b1;
    // Start cycle, 33 held wait cycles, then done in the 34th (limit) wait cycle.
    for (int i = 0; i <= 34; i++) begin
      mdu_done = (i == 34);
      #2;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ((d == 0 ? obs_a : obs_b) !== exp_vec(d)) begin
          errors++;
          $display("FAIL div_long[%0d] dut%0d got %h exp %h", i, d, (d == 0 ? obs_a : obs_b),
                   exp_vec(d));
        end
      end
      if (!a_pc_write) held++;
      advance();
    end
    set_idle();
    #2;
    checks++;
    if (held !== 34) begin
      errors++;
      $display("FAIL div_held_cycles got %0d exp 34", held);
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (a_stall - stall0 !== 32'd34) begin
      errors++;
      $display("FAIL div_stall_count got %0d exp 34", a_stall - stall0);
    end
`endif
    advance();
  endtask

  task automatic test_fault();
    do_reset();
    ex_is_mdu = 1'b1;
    for (int i = 0; i < 12; i++) begin
      // After the 4th wait cycle dut_b sits in FAULT; any input must leave it frozen.
      if (i > 4) begin
        mdu_done = 1'($urandom_range(0, 1));
        ex_branch_taken = 1'($urandom_range(0, 1));
        id_ex_memRead = 1'b1; id_ex_rd = 5'd4; id_rs1 = 5'd4; id_uses_rs1 = 1'b1;
      end
      #2;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ((d == 0 ? obs_a : obs_b) !== exp_vec(d)) begin
          errors++;
          $display("FAIL fault[%0d] dut%0d got %h exp %h", i, d, (d == 0 ? obs_a : obs_b),
                   exp_vec(d));
        end
      end
      advance();
    end
    checks++;
    if (b_mdu_timeout !== 1'b1 || b_pc_write !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky timeout=%b pc_write=%b exp 1 0", b_mdu_timeout, b_pc_write);
    end
    set_idle();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ex_is_mdu = 1'b1;
    for (int i = 0; i < 3; i++) advance();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ((d == 0 ? obs_a : obs_b) !== exp_vec(d)) begin
        errors++;
        $display("FAIL rst_mid_wait dut%0d got %h exp %h", d, (d == 0 ? obs_a : obs_b),
                 exp_vec(d));
      end
    end
    ex_is_mdu = 1'b0;
    advance();
    rst_n = 1'b1;
    mdu_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ((d == 0 ? obs_a : obs_b) !== exp_vec(d)) begin
          errors++;
          $display("FAIL spurious_done[%0d] dut%0d got %h exp %h", i, d,
                   (d == 0 ? obs_a : obs_b), exp_vec(d));
        end
      end
      advance();
      mdu_done = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    bit mdu_s[7]  = '{1, 1, 1, 1, 1, 1, 0};
    bit done_s[7] = '{0, 0, 1, 0, 0, 1, 0};
    int starts[$];
    do_reset();
    for (int i = 0; i < 7; i++) begin
      ex_is_mdu = mdu_s[i];
      mdu_done  = done_s[i];
      #2;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ((d == 0 ? obs_a : obs_b) !== exp_vec(d)) begin
          errors++;
          $display("FAIL b2b[%0d] dut%0d got %h exp %h", i, d, (d == 0 ? obs_a : obs_b),
                   exp_vec(d));
        end
      end
      if (a_mdu_start) starts.push_back(cyc);
      advance();
    end
    checks++;
    if (starts.size() != 2 || starts[1] - starts[0] != 3) begin
      errors++;
      $display("FAIL b2b_spacing pulses=%0d gap=%0d exp 2 pulses gap 3", starts.size(),
               (starts.size() == 2) ? starts[1] - starts[0] : -1);
    end
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_ex_rd        = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      id_ex_memRead   = 1'($urandom_range(0, 1));
      ex_is_mdu       = ($urandom_range(0, 7) == 0);
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      mdu_done        = ($urandom_range(0, 4) == 0) || (m_wait[0] && m_cnt[0] >= 8);
      #2;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ((d == 0 ? obs_a : obs_b) !== exp_vec(d)) begin
          errors++;
          $display("FAIL random[%0d] dut%0d got %h exp %h", i, d, (d == 0 ? obs_a : obs_b),
                   exp_vec(d));
        end
      end
      advance();
      if (i % 100 == 99) do_reset();
    end
    set_idle();
  endtask

  initial begin
    m_max[0] = 34;
    m_max[1] = 4;
    rst_n = 1'b0;
    model_reset();
    set_idle();
    advance();
    test_reset();
    test_load_use();
    test_branch();
    test_div_long();
    test_fault();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
